// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package rf_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MOV   = 4'd1,
    INCR  = 4'd2,
    DECR  = 4'd3,
    LITSH = 4'd4,
    SETB  = 4'd5,
    FLIPB = 4'd6,
    SHLC  = 4'd7,
    SHRC  = 4'd8,
    BIZR  = 4'd9,
    BNZR  = 4'd10
  } rf_op_t;

  // Register idx comes out of reset holding idx mod 2^width.
  function automatic int unsigned rst_val(int unsigned idx, int unsigned width);
    if (width >= 32) return idx;
    return idx % (32'd1 << width);
  endfunction

  function automatic logic op_reads_src(rf_op_t op);
    return op inside {MOV, INCR, DECR, BIZR, BNZR};
  endfunction

  function automatic logic op_uses_dst(rf_op_t op);
    return op inside {MOV, INCR, DECR, LITSH, SETB, FLIPB, SHLC, SHRC};
  endfunction

  function automatic logic op_writes_dst(rf_op_t op);
    return op inside {MOV, INCR, DECR, LITSH, SETB, FLIPB, SHLC, SHRC};
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decoder, read-port and load/store bundle seen by the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int IMM_W  = 4
);
  import rf_pkg::*;
  localparam int AW = $clog2(NREGS);

  logic              op_valid;
  rf_op_t            reg_op;
  logic [AW-1:0]     src;
  logic [AW-1:0]     dst;
  logic [IMM_W-1:0]  imm;
  logic [AW-1:0]     rd_a_addr;
  logic [AW-1:0]     rd_b_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic              ld_issue;
  logic [AW-1:0]     ld_dst;
  logic              ld_done;
  logic [AW-1:0]     ld_ret_dst;
  logic [DATA_W-1:0] ld_data;
  logic              stall;
  logic              branch_taken;
  logic [NREGS-1:0]  busy_vec;
  logic              sb_err;

  modport master (
    output op_valid, reg_op, src, dst, imm, rd_a_addr, rd_b_addr,
           ld_issue, ld_dst, ld_done, ld_ret_dst, ld_data,
    input  rd_a_data, rd_b_data, stall, branch_taken, busy_vec, sb_err
  );

  modport slave (
    input  op_valid, reg_op, src, dst, imm, rd_a_addr, rd_b_addr,
           ld_issue, ld_dst, ld_done, ld_ret_dst, ld_data,
    output rd_a_data, rd_b_data, stall, branch_taken, busy_vec, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Load scoreboard: per-register busy bits, sticky orphan-return error, op stall.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  rf_op_t           reg_op,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dst,
  input  logic             ld_done,
  input  logic [AW-1:0]    ld_ret_dst,
  output logic             ret_hit,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec,
  output logic             sb_err
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] ret_mask;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    ret_mask = '0;
    if (ld_done && busy_q[ld_ret_dst]) ret_mask[ld_ret_dst] = 1'b1;
  end

  // A register whose load returns this cycle is already usable via the bypass.
  assign ret_hit  = |ret_mask;
  assign eff_busy = busy_q & ~ret_mask;
  assign stall    = op_valid &&
                    ((op_reads_src(reg_op) && eff_busy[src]) ||
                     (op_uses_dst(reg_op)  && eff_busy[dst]));

  always_comb begin
    busy_nxt = busy_q & ~ret_mask;
    if (ld_issue && ld_dst != '0) busy_nxt[ld_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (ld_done && !busy_q[ld_ret_dst]) sb_err <= 1'b1;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// NREGS x DATA_W register file with two bypassed read ports, op datapath and load scoreboard.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int IMM_W  = 4
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]   regs [1:NREGS-1];
  logic [DATA_W-1:0]   view [NREGS];
  logic                ret_hit;
  logic                stall;
  logic [DATA_W-1:0]   src_v;
  logic [DATA_W-1:0]   dst_v;
  logic [DATA_W-1:0]   pair_v;
  int unsigned         sh;
  logic [2*DATA_W-1:0] funnel;
  logic [2*DATA_W-1:0] funnel_l;
  logic [2*DATA_W-1:0] funnel_r;
  logic [DATA_W-1:0]   op_res;
  logic                op_we;

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (bus.op_valid),
    .reg_op     (bus.reg_op),
    .src        (bus.src),
    .dst        (bus.dst),
    .ld_issue   (bus.ld_issue),
    .ld_dst     (bus.ld_dst),
    .ld_done    (bus.ld_done),
    .ld_ret_dst (bus.ld_ret_dst),
    .ret_hit    (ret_hit),
    .stall      (stall),
    .busy_vec   (bus.busy_vec),
    .sb_err     (bus.sb_err)
  );

  // Architectural view: r0 is hardwired zero, a returning load overrides its register.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      view[i] = (ret_hit && bus.ld_ret_dst == AW'(i)) ? bus.ld_data : regs[i];
    end
  end

  assign bus.rd_a_data = view[bus.rd_a_addr];
  assign bus.rd_b_data = view[bus.rd_b_addr];
  assign bus.stall     = stall;

  assign src_v  = view[bus.src];
  assign dst_v  = view[bus.dst];
  assign pair_v = view[bus.dst ^ AW'(1)];
  assign sh     = 32'(bus.imm) % DATA_W;

  assign funnel   = {dst_v, pair_v};
  assign funnel_l = funnel << sh;
  assign funnel_r = funnel >> sh;

  always_comb begin
    op_res = dst_v;
    unique case (bus.reg_op)
      MOV:     op_res = (bus.src == bus.dst) ? '0 : src_v;
      INCR:    op_res = src_v + DATA_W'(1);
      DECR:    op_res = src_v - DATA_W'(1);
      LITSH:   op_res = {dst_v[DATA_W-5:0], bus.imm[3:0]};
      SETB:    op_res = dst_v | (DATA_W'(1) << sh);
      FLIPB:   op_res = dst_v ^ (DATA_W'(1) << sh);
      SHLC:    op_res = funnel_l[2*DATA_W-1 -: DATA_W];
      SHRC:    op_res = funnel_r[2*DATA_W-1 -: DATA_W];
      default: op_res = dst_v;
    endcase
  end

  always_comb begin
    bus.branch_taken = 1'b0;
    if (bus.op_valid) begin
      if (bus.reg_op == BIZR) bus.branch_taken = (src_v == '0);
      if (bus.reg_op == BNZR) bus.branch_taken = (src_v != '0);
    end
  end

  assign op_we = bus.op_valid && !stall && op_writes_dst(bus.reg_op) && bus.dst != '0;

  // The retiring op is younger than any load returning to the same index, so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= DATA_W'(rst_val(i, DATA_W));
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (op_we && bus.dst == AW'(i))
          regs[i] <= op_res;
        else if (ret_hit && bus.ld_ret_dst == AW'(i))
          regs[i] <= bus.ld_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scenarios plus a randomized run against an array-based model of the register file.
module tb_regfile_sb;
  import rf_pkg::*;

  localparam int DATA_W = 8;
  localparam int NREGS  = 16;
  localparam int IMM_W  = 4;
  localparam int MOD    = 1 << DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m  [NREGS];
  bit mb [NREGS];
  bit merr;

  task automatic idle();
    bus.op_valid   = 1'b0;
    bus.reg_op     = NOP;
    bus.src        = '0;
    bus.dst        = '0;
    bus.imm        = '0;
    bus.rd_a_addr  = '0;
    bus.rd_b_addr  = '0;
    bus.ld_issue   = 1'b0;
    bus.ld_dst     = '0;
    bus.ld_done    = 1'b0;
    bus.ld_ret_dst = '0;
    bus.ld_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic op(rf_op_t o, int s, int d, int i);
    bus.op_valid = 1'b1;
    bus.reg_op   = o;
    bus.src      = 4'(s);
    bus.dst      = 4'(d);
    bus.imm      = 4'(i);
    tick();
    bus.op_valid = 1'b0;
    bus.reg_op   = NOP;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NREGS; i++) begin
      bus.rd_a_addr = 4'(i);
      bus.rd_b_addr = 4'(NREGS - 1 - i);
      #1;
      n_chk++;
      if (bus.rd_a_data !== 8'(i)) $display("FAIL reset_rd_a r%0d got %h want %h", i, bus.rd_a_data, 8'(i));
      else n_pass++;
      n_chk++;
      if (bus.rd_b_data !== 8'(NREGS - 1 - i)) $display("FAIL reset_rd_b r%0d got %h want %h", NREGS-1-i, bus.rd_b_data, 8'(NREGS-1-i));
      else n_pass++;
    end
    n_chk++;
    if (bus.busy_vec !== 16'h0000) $display("FAIL reset_busy got %h want 0000", bus.busy_vec);
    else n_pass++;
    n_chk++;
    if (bus.sb_err !== 1'b0 || bus.stall !== 1'b0 || bus.branch_taken !== 1'b0)
      $display("FAIL reset_ctrl got err=%b stall=%b br=%b want 0 0 0", bus.sb_err, bus.stall, bus.branch_taken);
    else n_pass++;
  endtask

  task automatic test_litsh_decr();
    op(LITSH, 0, 5, 'hA);
    op(LITSH, 0, 5, 'h3);
    bus.rd_a_addr = 4'd5;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'hA3) $display("FAIL litsh r5 got %h want a3", bus.rd_a_data);
    else n_pass++;
    for (int k = 0; k < 'hA4; k++) op(DECR, 5, 5, 0);
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'hFF) $display("FAIL decr_wrap r5 got %h want ff", bus.rd_a_data);
    else n_pass++;
    op(INCR, 5, 10, 0);
    bus.rd_b_addr = 4'd10;
    #1;
    n_chk++;
    if (bus.rd_b_data !== 8'h00) $display("FAIL incr_wrap r10 got %h want 00", bus.rd_b_data);
    else n_pass++;
    op(MOV, 8, 8, 0);
    bus.rd_b_addr = 4'd8;
    #1;
    n_chk++;
    if (bus.rd_b_data !== 8'h00) $display("FAIL mov_self r8 got %h want 00", bus.rd_b_data);
    else n_pass++;
    op(MOV, 7, 0, 0);
    bus.rd_b_addr = 4'd0;
    #1;
    n_chk++;
    if (bus.rd_b_data !== 8'h00) $display("FAIL r0_write got %h want 00", bus.rd_b_data);
    else n_pass++;
  endtask

  task automatic test_funnel();
    op(LITSH, 0, 6, 'h8);
    op(LITSH, 0, 6, 'h1);
    op(LITSH, 0, 7, 'hF);
    op(LITSH, 0, 7, 'h0);
    op(SHLC, 0, 6, 3);
    bus.rd_a_addr = 4'd6;
    bus.rd_b_addr = 4'd7;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h0F) $display("FAIL shlc r6 got %h want 0f", bus.rd_a_data);
    else n_pass++;
    n_chk++;
    if (bus.rd_b_data !== 8'hF0) $display("FAIL shlc_pair r7 got %h want f0", bus.rd_b_data);
    else n_pass++;
    op(SHRC, 0, 6, 4);
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h00) $display("FAIL shrc r6 got %h want 00", bus.rd_a_data);
    else n_pass++;
    op(SETB, 0, 6, 9);
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h02) $display("FAIL setb_mod r6 got %h want 02", bus.rd_a_data);
    else n_pass++;
    op(FLIPB, 0, 6, 7);
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h82) $display("FAIL flipb r6 got %h want 82", bus.rd_a_data);
    else n_pass++;
  endtask

  task automatic test_load_stall();
    bus.ld_issue = 1'b1;
    bus.ld_dst   = 4'd3;
    tick();
    bus.ld_issue = 1'b0;
    n_chk++;
    if (bus.busy_vec !== 16'h0008) $display("FAIL ld_busy got %h want 0008", bus.busy_vec);
    else n_pass++;
    bus.op_valid  = 1'b1;
    bus.reg_op    = MOV;
    bus.src       = 4'd3;
    bus.dst       = 4'd4;
    bus.rd_a_addr = 4'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++;
      if (bus.stall !== 1'b1 || bus.rd_a_data !== 8'h04)
        $display("FAIL stall_hold cyc %0d got stall=%b r4=%h want 1 04", c, bus.stall, bus.rd_a_data);
      else n_pass++;
      tick();
    end
    bus.ld_done    = 1'b1;
    bus.ld_ret_dst = 4'd3;
    bus.ld_data    = 8'h5C;
    bus.rd_b_addr  = 4'd3;
    #1;
    n_chk++;
    if (bus.stall !== 1'b0 || bus.rd_b_data !== 8'h5C)
      $display("FAIL ret_bypass got stall=%b rd_b=%h want 0 5c", bus.stall, bus.rd_b_data);
    else n_pass++;
    tick();
    idle();
    bus.rd_a_addr = 4'd4;
    bus.rd_b_addr = 4'd3;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h5C || bus.rd_b_data !== 8'h5C)
      $display("FAIL ret_write got r4=%h r3=%h want 5c 5c", bus.rd_a_data, bus.rd_b_data);
    else n_pass++;
    n_chk++;
    if (bus.busy_vec !== 16'h0000 || bus.sb_err !== 1'b0)
      $display("FAIL ret_clear got busy=%h err=%b want 0000 0", bus.busy_vec, bus.sb_err);
    else n_pass++;
  endtask

  task automatic test_sb_err();
    bus.ld_done    = 1'b1;
    bus.ld_ret_dst = 4'd9;
    bus.ld_data    = 8'hEE;
    tick();
    idle();
    bus.rd_a_addr = 4'd9;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h09 || bus.sb_err !== 1'b1)
      $display("FAIL orphan_ret got r9=%h err=%b want 09 1", bus.rd_a_data, bus.sb_err);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (bus.sb_err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.sb_err);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.sb_err !== 1'b0) $display("FAIL err_reset got %b want 0", bus.sb_err);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midload();
    do_reset();
    bus.ld_issue = 1'b1;
    bus.ld_dst   = 4'd0;
    tick();
    n_chk++;
    if (bus.busy_vec !== 16'h0000) $display("FAIL ld_r0 got busy=%h want 0000", bus.busy_vec);
    else n_pass++;
    bus.ld_dst = 4'd2;
    tick();
    bus.ld_issue = 1'b0;
    n_chk++;
    if (bus.busy_vec !== 16'h0004) $display("FAIL ld_r2 got busy=%h want 0004", bus.busy_vec);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.busy_vec !== 16'h0000) $display("FAIL midload_reset got busy=%h want 0000", bus.busy_vec);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    bus.rd_a_addr = 4'd2;
    bus.op_valid  = 1'b1;
    bus.reg_op    = BIZR;
    bus.src       = 4'd0;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h02 || bus.branch_taken !== 1'b1)
      $display("FAIL bizr_r0 got r2=%h br=%b want 02 1", bus.rd_a_data, bus.branch_taken);
    else n_pass++;
    bus.reg_op = BNZR;
    #1;
    n_chk++;
    if (bus.branch_taken !== 1'b0) $display("FAIL bnzr_r0 got %b want 0", bus.branch_taken);
    else n_pass++;
    bus.src = 4'd2;
    #1;
    n_chk++;
    if (bus.branch_taken !== 1'b1) $display("FAIL bnzr_r2 got %b want 1", bus.branch_taken);
    else n_pass++;
    idle();
    bus.ld_done    = 1'b1;
    bus.ld_ret_dst = 4'd2;
    bus.ld_data    = 8'h77;
    tick();
    idle();
    bus.rd_a_addr = 4'd2;
    #1;
    n_chk++;
    if (bus.rd_a_data !== 8'h02 || bus.sb_err !== 1'b1)
      $display("FAIL late_ret got r2=%h err=%b want 02 1", bus.rd_a_data, bus.sb_err);
    else n_pass++;
  endtask

  // Model: values seen this cycle, with a returning load visible only if its register is busy.
  function automatic int mrd(int i);
    if (i == 0) return 0;
    if (bus.ld_done && int'(bus.ld_ret_dst) == i && mb[i]) return int'(bus.ld_data);
    return m[i];
  endfunction

  function automatic bit meff_busy(int i);
    return mb[i] && !(bus.ld_done && int'(bus.ld_ret_dst) == i);
  endfunction

  function automatic int mresult(rf_op_t o, int s, int d, int i);
    int sv, dv, ov, k;
    sv = mrd(s);
    dv = mrd(d);
    ov = mrd(d ^ 1);
    k  = i % DATA_W;
    case (o)
      MOV:     return (s == d) ? 0 : sv;
      INCR:    return (sv + 1) % MOD;
      DECR:    return (sv + MOD - 1) % MOD;
      LITSH:   return (dv * 16 + i) % MOD;
      SETB:    return dv | (1 << k);
      FLIPB:   return dv ^ (1 << k);
      SHLC:    return (((dv * MOD + ov) << k) / MOD) % MOD;
      SHRC:    return ((dv * MOD + ov) >> k) / MOD;
      default: return dv;
    endcase
  endfunction

  task automatic test_random();
    rf_op_t o;
    int s, d, ret, res;
    bit rds, used, wr, exp_stall, exp_br;
    logic [15:0] exp_busy;
    do_reset();
    for (int i = 0; i < NREGS; i++) begin
      m[i]  = i % MOD;
      mb[i] = 1'b0;
    end
    merr = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      o = rf_op_t'(4'($urandom_range(0, 12)));
      s = $urandom_range(0, NREGS-1);
      d = $urandom_range(0, NREGS-1);
      bus.op_valid  = ($urandom_range(0, 3) != 0);
      bus.reg_op    = o;
      bus.src       = 4'(s);
      bus.dst       = 4'(d);
      bus.imm       = 4'($urandom_range(0, 15));
      bus.rd_a_addr = 4'($urandom_range(0, NREGS-1));
      bus.rd_b_addr = 4'($urandom_range(0, NREGS-1));
      bus.ld_issue  = ($urandom_range(0, 3) == 0);
      bus.ld_dst    = 4'($urandom_range(0, NREGS-1));
      bus.ld_done   = ($urandom_range(0, 2) == 0);
      ret = $urandom_range(0, NREGS-1);
      if ($urandom_range(0, 9) != 0) begin
        for (int j = 0; j < NREGS; j++) begin
          if (mb[(ret + j) % NREGS]) begin
            ret = (ret + j) % NREGS;
            break;
          end
        end
      end
      bus.ld_ret_dst = 4'(ret);
      bus.ld_data    = 8'($urandom_range(0, MOD-1));
      wr   = o inside {MOV, INCR, DECR, LITSH, SETB, FLIPB, SHLC, SHRC};
      rds  = o inside {MOV, INCR, DECR, BIZR, BNZR};
      used = wr;
      if (bus.ld_done && wr && d == ret) bus.op_valid = 1'b0;
      exp_stall = bus.op_valid && ((rds && meff_busy(s)) || (used && meff_busy(d)));
      exp_br    = bus.op_valid && ((o == BIZR && mrd(s) == 0) || (o == BNZR && mrd(s) != 0));
      #1;
      n_chk++;
      if (bus.rd_a_data !== 8'(mrd(int'(bus.rd_a_addr))) || bus.rd_b_data !== 8'(mrd(int'(bus.rd_b_addr))))
        $display("FAIL rand_read cyc %0d got %h %h want %h %h", cyc, bus.rd_a_data, bus.rd_b_data,
                 8'(mrd(int'(bus.rd_a_addr))), 8'(mrd(int'(bus.rd_b_addr))));
      else n_pass++;
      n_chk++;
      if (bus.stall !== exp_stall || bus.branch_taken !== exp_br)
        $display("FAIL rand_ctrl cyc %0d got stall=%b br=%b want %b %b", cyc, bus.stall, bus.branch_taken, exp_stall, exp_br);
      else n_pass++;
      res = mresult(o, s, d, int'(bus.imm));
      if (bus.ld_done) begin
        if (mb[ret]) begin
          if (ret != 0) m[ret] = int'(bus.ld_data);
          mb[ret] = 1'b0;
        end else begin
          merr = 1'b1;
        end
      end
      if (bus.op_valid && !exp_stall && wr && d != 0) m[d] = res;
      if (bus.ld_issue && bus.ld_dst != 0) mb[int'(bus.ld_dst)] = 1'b1;
      tick();
      for (int j = 0; j < NREGS; j++) exp_busy[j] = mb[j];
      n_chk++;
      if (bus.busy_vec !== exp_busy || bus.sb_err !== merr)
        $display("FAIL rand_sb cyc %0d got busy=%h err=%b want %h %b", cyc, bus.busy_vec, bus.sb_err, exp_busy, merr);
      else n_pass++;
    end
    idle();
    for (int i = 0; i < NREGS; i++) begin
      bus.rd_a_addr = 4'(i);
      #1;
      n_chk++;
      if (bus.rd_a_data !== 8'(mrd(i))) $display("FAIL rand_final r%0d got %h want %h", i, bus.rd_a_data, 8'(mrd(i)));
      else n_pass++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_litsh_decr();
    test_funnel();
    test_load_stall();
    test_sb_err();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
